// File: rtl/dmem_pkg.sv
// Shared types, constants and address checking for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned DMEM_DEPTH_WORDS = 1024;
  localparam int unsigned WORD_BYTES       = 4;

  // True when a byte address is not word aligned or lies beyond the memory.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = ((addr & 32'(WORD_BYTES - 1)) != 32'd0);
    out_of_range = ({2'b00, addr[31:2]} >= depth_words);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_grant_o
);

  logic [IDX_W-1:0] cand;

  // Scan ptr, ptr+1, ... modulo N_REQ and keep the first hit.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
      if (!any_grant_o && req_i[cand]) begin
        any_grant_o    = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port word memory between N_REQ requesters, one transaction at a time.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_write_data,
  input  logic [DATA_W-1:0]       mem_read_data,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_bad;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (win_oh),
    .grant_idx_o (win_idx),
    .any_grant_o (win_any)
  );

  // Unpack the flattened request buses and qualify the winner's address.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
    sel_addr = addr_arr[win_idx];
    sel_bad  = addr_is_bad(32'(sel_addr), DEPTH_WORDS);
  end

  // State and command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic: accept in IDLE, one memory cycle in ACCESS, wait for the owner in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    req_ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          req_ready = win_oh;
          grant_d   = win_idx;
          we_d      = req_we[win_idx];
          err_d     = sel_bad;
          if (!sel_bad) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = wdata_arr[win_idx];
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = (!err_q && !we_q) ? mem_read_data : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[grant_q]) begin
          ptr_d   = IDX_W'((32'(grant_q) + 32'd1) % N_REQ);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory strobes and response outputs; strobes are masked while reset is asserted.
  always_comb begin
    mem_read       = !rst && (state_q == ST_ACCESS) && !err_q && !we_q;
    mem_write      = !rst && (state_q == ST_ACCESS) && !err_q && we_q;
    mem_address    = mem_addr_q;
    mem_write_data = mem_wdata_q;
    rsp_rdata      = rdata_q;
    rsp_err        = err_q;
    busy           = (state_q != ST_IDLE);
    grant_id       = grant_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (state_q == ST_RESP) && (grant_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter with a transaction-level memory model.
module tb_dmem_arbiter;

  localparam int unsigned N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0]     rsp_rdata, mem_address, mem_write_data, mem_read_data;
  logic            rsp_err, mem_read, mem_write, busy;
  logic [0:0]      grant_id;

  dmem_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT, plus strobe counters.
  logic [31:0] mem [1024];
  bit          loaded = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0;
  assign mem_read_data = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[0] <= 32'd4; mem[1] <= 32'd5; mem[2] <= 32'd3; mem[3] <= 32'd1; mem[4] <= 32'd2;
      loaded <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[11:2]] <= mem_write_data;
    end
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  // Reference model state.
  logic [31:0] refmem [1024];
  int          model_ptr = 0;
  int          exp_rd_cnt = 0, exp_wr_cnt = 0;
  logic        cmd_we    [N];
  logic [31:0] cmd_addr  [N];
  logic [31:0] cmd_wdata [N];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'($urandom_range(0, 15)) << 2;
      3:       return 32'hFFC;
      4:       return 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      default: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    endcase
  endfunction

  // One full transaction: offer the masked requests, check grant, memory cycle and response.
  task automatic run_txn(input logic [N-1:0] mask, input int hold, output int w);
    logic        err;
    logic [31:0] exp_rd;
    int          budget;
    int          j;
    req_valid = mask;
    for (int r = 0; r < N; r++) begin
      req_we[r]            = cmd_we[r];
      req_addr[r*32 +: 32]  = cmd_addr[r];
      req_wdata[r*32 +: 32] = cmd_wdata[r];
    end
    w = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (model_ptr + k) % N;
      if (mask[j]) w = j;
    end
    err    = (cmd_addr[w][1:0] != 2'b00) || (cmd_addr[w] >= 32'd4096);
    exp_rd = (err || cmd_we[w]) ? 32'd0 : refmem[cmd_addr[w][11:2]];
    if (!err && cmd_we[w])  begin refmem[cmd_addr[w][11:2]] = cmd_wdata[w]; exp_wr_cnt++; end
    if (!err && !cmd_we[w]) exp_rd_cnt++;
    #1;
    budget = 0;
    while (req_ready == '0 && budget < 4) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("req_ready_grant", 32'(req_ready), 32'(1 << w));
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    chk("access_mem_read", 32'(mem_read), 32'(!err && !cmd_we[w]));
    chk("access_mem_write", 32'(mem_write), 32'(!err && cmd_we[w]));
    if (!err) chk("access_mem_address", mem_address, cmd_addr[w]);
    if (!err && cmd_we[w]) chk("access_wdata", mem_write_data, cmd_wdata[w]);
    chk("access_busy", 32'(busy), 32'd1);
    chk("access_grant_id", 32'(grant_id), 32'(w));
    chk("access_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid", 32'(rsp_valid), 32'(1 << w));
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", 32'(rsp_err), 32'(err));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = N'(~(1 << w));
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'(1 << w));
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_no_grant", 32'(req_ready), 32'd0);
    end
    rsp_ready = N'(1 << w);
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mem_read_pulses", 32'(rd_cnt), 32'(exp_rd_cnt));
    chk("mem_write_pulses", 32'(wr_cnt), 32'(exp_wr_cnt));
    model_ptr = (w + 1) % N;
  endtask

  task automatic set_cmd(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
    cmd_we[r] = we; cmd_addr[r] = a; cmd_wdata[r] = d;
  endtask

  initial begin
    int          w;
    logic [N-1:0] cur_mask;
    for (int i = 0; i < 1024; i++) refmem[i] = 32'd0;
    refmem[0] = 32'd4; refmem[1] = 32'd5; refmem[2] = 32'd3; refmem[3] = 32'd1; refmem[4] = 32'd2;
    for (int r = 0; r < N; r++) set_cmd(r, 1'b0, 32'd0, 32'd0);
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load of word 2, then store/load round trip from requester 1.
    set_cmd(0, 1'b0, 32'h8, 32'd0);           run_txn(2'b01, 0, w);
    set_cmd(1, 1'b1, 32'h10, 32'h2A);         run_txn(2'b10, 1, w);
    set_cmd(1, 1'b0, 32'h10, 32'd0);          run_txn(2'b10, 0, w);
    // Misaligned, just out of range, and last legal word.
    set_cmd(0, 1'b0, 32'h6, 32'd0);           run_txn(2'b01, 0, w);
    set_cmd(0, 1'b0, 32'h1000, 32'd0);        run_txn(2'b01, 0, w);
    set_cmd(0, 1'b1, 32'h1000, 32'h55);       run_txn(2'b01, 0, w);
    set_cmd(0, 1'b0, 32'hFFC, 32'd0);         run_txn(2'b01, 0, w);

    // Reset during the memory cycle of a store must drop it without a response.
    req_valid = 2'b01; req_we[0] = 1'b1;
    req_addr[31:0] = 32'h4; req_wdata[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("rst_txn_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rst_gate_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_txn_busy", 32'(busy), 32'd0);
    chk("rst_txn_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst_txn_still_idle", 32'(rsp_valid), 32'd0);
    chk("rst_txn_write_pulses", 32'(wr_cnt), 32'(exp_wr_cnt));
    model_ptr = 0;

    // Both requesters contend: alternating grants, responses held with foreign rsp_ready.
    set_cmd(0, 1'b0, 32'h4, 32'd0);
    set_cmd(1, 1'b0, 32'h0, 32'd0);
    cur_mask = 2'b11;
    for (int t = 0; t < 4; t++) begin
      run_txn(cur_mask, 3, w);
      chk("rr_order", 32'(w), 32'(t % 2));
    end

    // Randomized traffic against the model.
    cur_mask = '0;
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < N; r++) begin
        if (!cur_mask[r]) begin
          set_cmd(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
          cur_mask[r] = 1'($urandom_range(0, 1));
        end
      end
      if (cur_mask == '0) cur_mask[$urandom_range(0, N - 1)] = 1'b1;
      run_txn(cur_mask, int'($urandom_range(0, 2)), w);
      cur_mask[w] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single-port word data memory between N_REQ requesters, for example the CPU load/store stage (req 0) and a debug/DMA loader (req 1).
- Accepts one request at a time over a valid/ready handshake.
- Drives the memory's mem_read/mem_write/address/write_data for exactly one cycle.
- Registers the read data and returns it with a per-requester response handshake.
- Misaligned and out-of-range accesses are rejected with an error response; memory is not touched.

Parameters:
N_REQ, 2, number of requesters (2..4)
DEPTH_WORDS, 1024, memory depth in 32-bit words; word index addr[31:2] must be < DEPTH_WORDS
ADDR_W, 32, byte address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  request pending, one bit per requester
req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
req_we  in  N_REQ  1 = store, 0 = load
req_addr  in  N_REQ*ADDR_W  flattened byte addresses; requester i uses slice i
req_wdata  in  N_REQ*DATA_W  flattened store data
rsp_valid  out  N_REQ  response available to requester i (one-hot or zero)
rsp_ready  in  N_REQ  requester i consumes the response
rsp_rdata  out  DATA_W  load data, shared bus; 0 for stores and errors
rsp_err  out  1  response is an error (misaligned or out of range)
mem_read  out  1  to data memory read enable
mem_write  out  1  to data memory write enable
mem_address  out  ADDR_W  to data memory byte address
mem_write_data  out  DATA_W  to data memory
mem_read_data  in  DATA_W  from data memory (combinational read)
busy  out  1  state != IDLE
grant_id  out  clog2(N_REQ)  owner of the current transaction

Behaviour:
Reset:
- state=IDLE, rr_ptr=0, and all command and response registers are 0.
- All outputs are 0.
- mem_read and mem_write are additionally gated by ~rst, so no write can commit in a cycle where rst=1.
- A reset in any state drops the in-flight transaction with no response.

IDLE:
- winner = first i with req_valid[i], scanning from rst ptr: rr_ptr, rr_ptr+1, ... mod N_REQ.
- req_ready[winner]=1 combinationally, only in IDLE.
- On handshake, latch addr, wdata, we, grant_id=winner, and err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
- Next state ACCESS. No valid requests: stay in IDLE.

ACCESS (exactly 1 cycle):
- If !err: mem_address=latched addr, and mem_read=!we, mem_write=we, mem_write_data=latched wdata. The store commits at the end of this cycle.
- Load data is captured from mem_read_data into rsp_rdata at the end of this cycle.
- If err: mem_read=mem_write=0 and rsp_rdata=0.
- Next state RESP.
- Outside ACCESS: mem_read=mem_write=0; mem_address and mem_write_data hold their last values.

RESP:
- rsp_valid[grant_id]=1; rsp_rdata and rsp_err are stable.
- Other requesters' rsp_ready is ignored.
- On rsp_ready[grant_id]: rr_ptr=(grant_id+1) mod N_REQ, next state IDLE.
- Otherwise hold indefinitely; there is no timeout.

Timing:
- Latency is handshake cycle N -> memory cycle N+1 -> rsp_valid from N+2.
- Peak throughput is 1 transaction per 3 cycles.

Boundary conditions:
- Simultaneous requests: round-robin order guarantees no starvation; each requester waits at most N_REQ-1 transactions.
- A requester must hold req_valid/addr/wdata/we stable until req_ready.
- Dropping req_valid before grant is legal; it is simply not selected.
- A requester may assert req_valid while its own response is pending; it is not granted until after IDLE is re-entered.
- Address DEPTH_WORDS*4-4 is legal; DEPTH_WORDS*4 is an error.
- Stores return rsp_rdata=0 and rsp_err=0.

Decomposition:
Shared package dmem_pkg holds:
- state encoding (IDLE, ACCESS, RESP)
- DMEM_DEPTH_WORDS=1024 and WORD_BYTES=4
- the error-check function (alignment and range)

One sub-module, rr_arbiter:
- inputs: req vector, pointer
- outputs: one-hot grant, grant index, any_grant
- purely combinational and reusable.

The FSM, registers and memory muxing stay in dmem_arbiter.

Test Plan:
1. Memory preloaded with words 0..4 = 4,5,3,1,2; req0 loads 0x8 -> mem_read pulses 1 cycle with mem_address=0x8; rsp_valid[0] 2 cycles after handshake with rsp_rdata=3, rsp_err=0.
2. req1 stores 0x0000002A to 0x10, then req1 loads 0x10 -> mem_write high exactly 1 cycle; subsequent load returns 42.
3. req0 and req1 both hold req_valid for 4 transactions after reset -> grant order 0,1,0,1; each response holds while rsp_ready=0 for 3 cycles and no new grant occurs.
4. req0 loads 0x6 (misaligned) and 0x1000 (word 1024) -> rsp_err=1, rsp_rdata=0, mem_read and mem_write never asserted; load of 0xFFC succeeds.
5. rst asserted during the ACCESS cycle of a store to 0x4 -> word 1 still reads 5 afterwards; no rsp_valid; rr_ptr=0 and busy=0 the cycle after.
6. rsp_ready asserted on a non-owner requester during RESP -> ignored, rsp_valid stays on the owner until its own rsp_ready.
